// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Forward key expansion to round key 10, then inverse key steps per round.
package aes_inv_pkg;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] ixt(input logic [7:0] x);
    return (x == 8'h1b) ? 8'h80 : {1'b0, x[7:1]};
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x,
                                      input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = x;
    for (int i = 1; i < 8; i++) begin
      b = gmul(b, b);
      r = gmul(r, b);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^
        gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^
        gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^
        gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^
        gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

endpackage

module sbox
  import aes_inv_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] f;
  assign f = ginv(a);
  assign y = f ^ rotl(f, 1) ^ rotl(f, 2) ^
             rotl(f, 3) ^ rotl(f, 4) ^ 8'h63;
endmodule

module inv_sbox
  import aes_inv_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] g;
  assign g = rotl(a, 1) ^ rotl(a, 3) ^
             rotl(a, 6) ^ 8'h05;
  assign y = ginv(g);
endmodule

module aes_inv_cipher_core
  import aes_inv_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE, KEYEXP, INIT, ROUND, FINAL, DONE
  } state_t;

  localparam logic [3:0] NRL = 4'(NR);

  state_t state, nxt;
  logic [127:0] st, rk;
  logic [7:0]   rcon;
  logic [3:0]   cnt;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p1, p2, p3, k0;
  logic [31:0] n1, n2, n3;
  logic [31:0] sw_in, rot, sw;
  logic [127:0] isr, sub, ark;
  logic [127:0] fwd_rk, inv_rk;

  assign {w0, w1, w2, w3} = rk;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // the four key sboxes serve both schedule directions
  assign sw_in = (state == KEYEXP) ? w3 : p3;
  assign rot = {sw_in[23:0], sw_in[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_ksb
    sbox u_sb (
      .a(rot[31-8*i -: 8]),
      .y(sw[31-8*i -: 8])
    );
  end

  assign k0 = w0 ^ sw ^ {rcon, 24'h0};
  assign n1 = w1 ^ k0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign fwd_rk = {k0, n1, n2, n3};
  assign inv_rk = {k0, p1, p2, p3};

  assign isr = inv_shift_rows(st);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    inv_sbox u_isb (
      .a(isr[127-8*i -: 8]),
      .y(sub[127-8*i -: 8])
    );
  end

  assign ark = sub ^ rk;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: if (load) nxt = KEYEXP;
      KEYEXP:     if (cnt == NRL) nxt = INIT;
      INIT:       nxt = ROUND;
      ROUND:      if (cnt == NRL - 4'd1) nxt = FINAL;
      FINAL:      nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= '0;
      rk        <= '0;
      rcon      <= 8'h01;
      cnt       <= '0;
      plaintext <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (load) begin
            rk   <= key;
            st   <= ciphertext;
            rcon <= 8'h01;
            cnt  <= 4'd1;
            done <= 1'b0;
            busy <= 1'b1;
          end
        end
        KEYEXP: begin
          rk  <= fwd_rk;
          cnt <= cnt + 4'd1;
          // rcon stops at 36 to seed the inverse schedule
          if (cnt != NRL) rcon <= xt(rcon);
        end
        INIT: begin
          st   <= st ^ rk;
          rk   <= inv_rk;
          rcon <= ixt(rcon);
          cnt  <= 4'd1;
        end
        ROUND: begin
          st   <= inv_mix_columns(ark);
          rk   <= inv_rk;
          rcon <= ixt(rcon);
          cnt  <= cnt + 4'd1;
        end
        FINAL: begin
          plaintext <= ark;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Bench for aes_inv_cipher_core: table-driven AES decrypt model
// plus edge-count timeline, compared every cycle.
module tb_aes_inv_cipher_core;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;

  int tot = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] sb [256];
  logic [7:0] isb [256];

  aes_inv_cipher_core #(.NR(10)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .key(key),
    .ciphertext(ciphertext),
    .plaintext(plaintext),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    tot++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [7:0] rol8(input logic [7:0] x,
                                      input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] xt8(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= t;
      t = xt8(t);
    end
    return p;
  endfunction

  // classic generator walk over powers of 3 and their inverses
  task automatic gen_sbox();
    logic [7:0] p = 8'h01;
    logic [7:0] q = 8'h01;
    logic [7:0] x;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] aes_dec(input logic [127:0] k,
                                           input logic [127:0] c);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]],
               sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt8(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) begin
      tmp = w[40 + i/4];
      s[i] = c[127-8*i -: 8] ^ tmp[31-8*(i%4) -: 8];
    end
    for (int r = 9; r >= 0; r--) begin
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          t[4*col+row] = s[4*((col-row+4)%4)+row];
      for (int i = 0; i < 16; i++) begin
        tmp = w[4*r + i/4];
        s[i] = isb[t[i]] ^ tmp[31-8*(i%4) -: 8];
      end
      if (r > 0) begin
        for (int col = 0; col < 4; col++) begin
          t[0] = s[4*col]; t[1] = s[4*col+1];
          t[2] = s[4*col+2]; t[3] = s[4*col+3];
          s[4*col]   = gm(t[0], 8'h0e) ^ gm(t[1], 8'h0b) ^
                       gm(t[2], 8'h0d) ^ gm(t[3], 8'h09);
          s[4*col+1] = gm(t[0], 8'h09) ^ gm(t[1], 8'h0e) ^
                       gm(t[2], 8'h0b) ^ gm(t[3], 8'h0d);
          s[4*col+2] = gm(t[0], 8'h0d) ^ gm(t[1], 8'h09) ^
                       gm(t[2], 8'h0e) ^ gm(t[3], 8'h0b);
          s[4*col+3] = gm(t[0], 8'h0b) ^ gm(t[1], 8'h0d) ^
                       gm(t[2], 8'h09) ^ gm(t[3], 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // timeline model: result appears 21 edges after the accept edge
  bit           m_run;
  int           m_n;
  logic [127:0] m_pend;
  logic         e_busy, e_done;
  logic [127:0] e_pt;

  always @(posedge clk) begin
    if (reset) begin
      m_run  <= 1'b0;
      e_busy <= 1'b0;
      e_done <= 1'b0;
      e_pt   <= '0;
    end else if (!m_run && load) begin
      m_run  <= 1'b1;
      m_n    <= 0;
      m_pend <= aes_dec(key, ciphertext);
      e_busy <= 1'b1;
      e_done <= 1'b0;
    end else if (m_run) begin
      if (m_n == 20) begin
        m_run  <= 1'b0;
        e_busy <= 1'b0;
        e_done <= 1'b1;
        e_pt   <= m_pend;
      end else begin
        m_n <= m_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 128'(busy), 128'(e_busy));
      chk("cyc_done", 128'(done), 128'(e_done));
      chk("cyc_pt", plaintext, e_pt);
    end
  end

  task automatic start(input logic [127:0] k, input logic [127:0] c);
    @(negedge clk);
    key = k;
    ciphertext = c;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_cyc);
    int i;
    for (i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(nm, 128'(i), 128'(exp_cyc));
  endtask

  initial begin
    int i;
    logic [127:0] rk_, rc_;
    reset = 1'b1;
    load = 1'b0;
    key = '0;
    ciphertext = '0;
    gen_sbox();
    chk("sbox53", 128'(sb[8'h53]), 128'h00ed);
    chk("model_b", aes_dec(KB, CB), PB);
    chk("model_c", aes_dec(KC, CC), PC);

    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_pt", plaintext, 128'h0);
    chk("rst_rcon", 128'(dut.rcon), 128'h01);
    chk("rst_cnt", 128'(dut.cnt), 128'h0);
    chk_en = 1'b1;
    reset = 1'b0;

    start(KB, CB);
    repeat (10) @(negedge clk);
    chk("rk_e10", dut.rk, RK10);
    wait_done("lat_b", 11);
    chk("pt_b", plaintext, PB);
    chk("rk_e21", dut.rk, KB);

    start(KC, CC);
    wait_done("lat_c", 21);
    chk("pt_c", plaintext, PC);

    start(KB, CB);
    repeat (4) @(negedge clk);
    key = KC;
    ciphertext = CC;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done("lat_ign", 16);
    chk("pt_ign", plaintext, PB);

    start(KB, CB);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy", 128'(busy), 128'h0);
    chk("mid_done", 128'(done), 128'h0);
    chk("mid_pt", plaintext, 128'h0);
    start(KC, CC);
    wait_done("lat_rst", 21);
    chk("pt_rst", plaintext, PC);

    @(negedge clk);
    key = KB;
    ciphertext = CB;
    load = 1'b1;
    for (i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("b2b_lat1", 128'(i), 128'd22);
    chk("b2b_pt1", plaintext, PB);
    key = KC;
    ciphertext = CC;
    @(negedge clk);
    chk("b2b_pulse", 128'(done), 128'h0);
    wait_done("b2b_lat2", 21);
    chk("b2b_pt2", plaintext, PC);
    load = 1'b0;

    for (int n = 0; n < 8; n++) begin
      rk_ = {$urandom, $urandom, $urandom, $urandom};
      rc_ = {$urandom, $urandom, $urandom, $urandom};
      start(rk_, rc_);
      for (int j = 0; j < 19; j++) begin
        @(negedge clk);
        key = {$urandom, $urandom, $urandom, $urandom};
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        load = 1'($urandom_range(0, 1));
      end
      load = 1'b0;
      wait_done("lat_rnd", 2);
      chk("pt_rnd", plaintext, aes_dec(rk_, rc_));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
